// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V core constants and register-index helpers
package riscv_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // One-hot register mask; x0 maps to an empty mask so it can never become busy.
  function automatic logic [NUM_REGS-1:0] reg_bit(input logic [REG_IDX_W-1:0] idx);
    reg_bit = '0;
    if (idx != '0) reg_bit[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID/WB hazard-tracking bus between the core and the scoreboard
interface hazard_scoreboard_if import riscv_pkg::*; #(
  parameter int MAX_PENDING = 4
) ();

  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  logic                 id_valid;
  logic [REG_IDX_W-1:0] id_rs1;
  logic [REG_IDX_W-1:0] id_rs2;
  logic                 id_uses_rs1;
  logic                 id_uses_rs2;
  logic [REG_IDX_W-1:0] id_rd;
  logic                 id_reg_write;
  logic                 id_long_lat;
  logic                 flush_id;
  logic                 wb_valid;
  logic [REG_IDX_W-1:0] wb_rd;
  logic                 stall_id;
  logic [NUM_REGS-1:0]  busy_vec;
  logic [CNT_W-1:0]     pending_cnt;
  logic [31:0]          stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_write, id_long_lat, flush_id, wb_valid, wb_rd,
    input  stall_id, busy_vec, pending_cnt, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_write, id_long_lat, flush_id, wb_valid, wb_rd,
    output stall_id, busy_vec, pending_cnt, stall_cycles
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - issue-side RAW/WAW/structural hazard tracker for long-latency writers
// Optional stall performance counter enabled by SCOREBOARD_PERF_EN.
module hazard_scoreboard import riscv_pkg::*; #(
  parameter int MAX_PENDING = 4
) (
  input  logic                clk,
  input  logic                rst,
  hazard_scoreboard_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  logic [NUM_REGS-1:0] r_busy;
  logic [CNT_W-1:0]    r_pending;

  logic [NUM_REGS-1:0] w_wb_bit;
  logic [NUM_REGS-1:0] w_busy_eff;
  logic [NUM_REGS-1:0] w_issue_bit;
  logic                w_full;
  logic                w_hazard;
  logic                w_stall;
  logic                w_issue;
  logic                w_retire;

  // A result retiring this cycle is forwarded to decode, so it no longer blocks.
  assign w_wb_bit   = bus.wb_valid ? reg_bit(bus.wb_rd) : '0;
  assign w_busy_eff = r_busy & ~w_wb_bit;
  assign w_full     = (r_pending == CNT_W'(MAX_PENDING));

  assign w_hazard = bus.id_valid &
                    ((bus.id_uses_rs1 & w_busy_eff[bus.id_rs1]) |
                     (bus.id_uses_rs2 & w_busy_eff[bus.id_rs2]) |
                     (bus.id_reg_write & w_busy_eff[bus.id_rd]) |
                     (bus.id_long_lat & bus.id_reg_write & w_full));

  assign w_stall  = w_hazard & ~bus.flush_id;
  assign w_issue  = bus.id_valid & ~w_stall & ~bus.flush_id & bus.id_reg_write &
                    bus.id_long_lat & (bus.id_rd != '0);
  assign w_retire = |(w_wb_bit & r_busy);

  assign w_issue_bit = w_issue ? reg_bit(bus.id_rd) : '0;

  // Clear before set: a forced same-register issue/retire leaves the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= '0;
      r_pending <= '0;
    end else begin
      r_busy    <= (r_busy & ~w_wb_bit) | w_issue_bit;
      r_pending <= r_pending + CNT_W'(w_issue) - CNT_W'(w_retire);
    end
  end

  assign bus.stall_id    = w_stall;
  assign bus.busy_vec    = r_busy;
  assign bus.pending_cnt = r_pending;

`ifdef SCOREBOARD_PERF_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
`else
  assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - randomized and directed bench for hazard_scoreboard against a queue model
module tb_hazard_scoreboard;

  localparam int MAXP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.MAX_PENDING(MAXP)) bus ();

  hazard_scoreboard #(.MAX_PENDING(MAXP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: list of registers whose long-latency result is still outstanding.
  int          q[$];
  logic [31:0] m_perf = 0;

  logic        obs_stall, exp_stall;
  logic [31:0] obs_busy, exp_busy;
  int          obs_cnt, exp_cnt;
  logic [31:0] obs_perf, exp_perf;

  function automatic int q_find(int r);
    foreach (q[i]) if (q[i] == r) return i;
    return -1;
  endfunction

  function automatic bit m_busy(int r);
    if (r == 0) return 0;
    if (bus.wb_valid && int'(bus.wb_rd) == r) return 0;
    return q_find(r) >= 0;
  endfunction

  function automatic bit m_stall();
    bit hz;
    hz = bus.id_valid &&
         ((bus.id_uses_rs1 && m_busy(int'(bus.id_rs1))) ||
          (bus.id_uses_rs2 && m_busy(int'(bus.id_rs2))) ||
          (bus.id_reg_write && m_busy(int'(bus.id_rd))) ||
          (bus.id_long_lat && bus.id_reg_write && q.size() == MAXP));
    return hz && !bus.flush_id;
  endfunction

  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit rw, input bit ll, input bit fl,
                       input bit wv, input int wr);
    bus.id_valid     = v;
    bus.id_rs1       = 5'(rs1);
    bus.id_uses_rs1  = u1;
    bus.id_rs2       = 5'(rs2);
    bus.id_uses_rs2  = u2;
    bus.id_rd        = 5'(rd);
    bus.id_reg_write = rw;
    bus.id_long_lat  = ll;
    bus.flush_id     = fl;
    bus.wb_valid     = wv;
    bus.wb_rd        = 5'(wr);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Samples DUT and model away from the edge, then advances the model across one rising edge.
  task automatic step();
    bit iss;
    int idx;
    @(negedge clk);
    obs_stall = bus.stall_id;
    obs_busy  = bus.busy_vec;
    obs_cnt   = int'(bus.pending_cnt);
    obs_perf  = bus.stall_cycles;
    exp_stall = m_stall();
    exp_busy  = '0;
    foreach (q[i]) exp_busy[q[i]] = 1'b1;
    exp_cnt   = q.size();
    exp_perf  = m_perf;
    if (rst) begin
      q.delete();
      m_perf = 0;
    end else begin
      iss = bus.id_valid && !exp_stall && !bus.flush_id && bus.id_reg_write &&
            bus.id_long_lat && bus.id_rd != 0;
      if (bus.wb_valid && bus.wb_rd != 0) begin
        idx = q_find(int'(bus.wb_rd));
        if (idx >= 0) q.delete(idx);
      end
      if (iss && q_find(int'(bus.id_rd)) < 0) q.push_back(int'(bus.id_rd));
`ifdef SCOREBOARD_PERF_EN
      if (exp_stall && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    m_perf = 0;
    rst = 1'b0;
    drive(1, 5, 1, 6, 1, 7, 1, 1, 0, 0, 0);
    step();
    n_vec++; if (obs_busy !== 32'h0) begin n_err++; $display("FAIL reset_busy got=%h exp=0", obs_busy); end
    n_vec++; if (obs_cnt != 0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", obs_cnt); end
    n_vec++; if (obs_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", obs_stall); end
    n_vec++; if (obs_perf !== 32'h0) begin n_err++; $display("FAIL reset_perf got=%h exp=0", obs_perf); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    step();
  endtask

  task automatic test_load_use();
    drive(1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0);
    step();
    drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (obs_stall !== exp_stall || obs_stall !== 1'b1) begin
        n_err++; $display("FAIL load_use_stall cyc=%0d got=%b exp=%b", i, obs_stall, exp_stall);
      end
      n_vec++; if (obs_busy !== exp_busy) begin
        n_err++; $display("FAIL load_use_busy got=%h exp=%h", obs_busy, exp_busy);
      end
    end
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    step();
    n_vec++; if (obs_stall !== 1'b0) begin n_err++; $display("FAIL load_use_retire_stall got=%b exp=0", obs_stall); end
    n_vec++; if (obs_busy[5] !== 1'b1) begin n_err++; $display("FAIL load_use_busy5_pre got=%b exp=1", obs_busy[5]); end
    idle();
    step();
    n_vec++; if (obs_busy !== 32'h0 || obs_cnt != 0) begin
      n_err++; $display("FAIL load_use_clear busy=%h cnt=%0d exp 0/0", obs_busy, obs_cnt);
    end
  endtask

  task automatic test_x0();
    drive(1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    step();
    drive(1, 0, 1, 0, 1, 9, 1, 0, 0, 0, 0);
    step();
    n_vec++; if (obs_busy !== 32'h0 || obs_cnt != 0) begin
      n_err++; $display("FAIL x0_state busy=%h cnt=%0d exp 0/0", obs_busy, obs_cnt);
    end
    n_vec++; if (obs_stall !== 1'b0) begin n_err++; $display("FAIL x0_stall got=%b exp=0", obs_stall); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step();
    n_vec++; if (obs_cnt != 0) begin n_err++; $display("FAIL x0_retire_cnt got=%0d exp=0", obs_cnt); end
  endtask

  task automatic test_structural();
    for (int r = 1; r <= 4; r++) begin
      drive(1, 0, 0, 0, 0, r, 1, 1, 0, 0, 0);
      step();
    end
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
    step();
    n_vec++; if (obs_stall !== 1'b1 || obs_cnt != MAXP) begin
      n_err++; $display("FAIL struct_full stall=%b cnt=%0d exp 1/%0d", obs_stall, obs_cnt, MAXP);
    end
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd2;
    step();
    n_vec++; if (obs_stall !== exp_stall) begin n_err++; $display("FAIL struct_retire_stall got=%b exp=%b", obs_stall, exp_stall); end
    bus.wb_valid = 1'b0;
    step();
    n_vec++; if (obs_stall !== 1'b0) begin n_err++; $display("FAIL struct_issue_stall got=%b exp=0", obs_stall); end
    idle();
    step();
    n_vec++; if (obs_cnt != MAXP || obs_busy !== 32'h9A) begin
      n_err++; $display("FAIL struct_after cnt=%0d busy=%h exp %0d/0000009a", obs_cnt, obs_busy, MAXP);
    end
    foreach (exp_busy[r]) if (r != 0 && obs_busy[r]) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, r);
      step();
    end
    idle();
    step();
    n_vec++; if (obs_cnt != 0) begin n_err++; $display("FAIL struct_drain cnt=%0d exp=0", obs_cnt); end
  endtask

  task automatic test_waw();
    drive(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0);
    step();
    drive(1, 0, 1, 0, 0, 8, 1, 0, 0, 0, 0);
    step();
    n_vec++; if (obs_stall !== 1'b1) begin n_err++; $display("FAIL waw_stall got=%b exp=1", obs_stall); end
    drive(1, 0, 1, 8, 0, 9, 1, 0, 0, 0, 0);
    step();
    n_vec++; if (obs_stall !== 1'b0) begin n_err++; $display("FAIL waw_unused_rs2 got=%b exp=0", obs_stall); end
    drive(1, 0, 1, 0, 0, 8, 1, 0, 0, 1, 8);
    step();
    n_vec++; if (obs_stall !== 1'b0) begin n_err++; $display("FAIL waw_retire got=%b exp=0", obs_stall); end
  endtask

  task automatic test_flush();
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
    step();
    drive(1, 3, 1, 0, 0, 10, 1, 1, 1, 0, 0);
    step();
    n_vec++; if (obs_stall !== 1'b0) begin n_err++; $display("FAIL flush_stall got=%b exp=0", obs_stall); end
    drive(1, 0, 0, 0, 0, 11, 1, 1, 1, 0, 0);
    step();
    idle();
    step();
    n_vec++; if (obs_busy !== 32'h8 || obs_busy !== exp_busy) begin
      n_err++; $display("FAIL flush_busy got=%h exp=%h", obs_busy, exp_busy);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    step();
  endtask

`ifdef SCOREBOARD_PERF_EN
  task automatic test_perf();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    step();
    drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    repeat (3) step();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    step();
    idle();
    step();
    n_vec++; if (obs_perf !== 32'd3) begin n_err++; $display("FAIL perf_count got=%0d exp=3", obs_perf); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    n_vec++; if (obs_perf !== 32'd0) begin n_err++; $display("FAIL perf_reset got=%0d exp=0", obs_perf); end
  endtask
`endif

  task automatic test_random();
    int wr;
    for (int it = 0; it < 600; it++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 9) == 0, 0, 0);
      if ($urandom_range(0, 2) == 0) begin
        wr = (q.size() != 0 && $urandom_range(0, 3) != 0) ? q[$urandom_range(0, q.size() - 1)]
                                                          : int'($urandom_range(0, 7));
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'(wr);
      end
      rst = ($urandom_range(0, 149) == 0);
      step();
      n_vec++; if (obs_stall !== exp_stall) begin n_err++; $display("FAIL rnd_stall it=%0d got=%b exp=%b", it, obs_stall, exp_stall); end
      n_vec++; if (obs_busy !== exp_busy) begin n_err++; $display("FAIL rnd_busy it=%0d got=%h exp=%h", it, obs_busy, exp_busy); end
      n_vec++; if (obs_cnt != exp_cnt) begin n_err++; $display("FAIL rnd_cnt it=%0d got=%0d exp=%0d", it, obs_cnt, exp_cnt); end
      n_vec++; if (obs_perf !== exp_perf) begin n_err++; $display("FAIL rnd_perf it=%0d got=%0d exp=%0d", it, obs_perf, exp_perf); end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_structural();
    test_waw();
    test_flush();
`ifdef SCOREBOARD_PERF_EN
    test_perf();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
